mipi_clk_lane_tx_ctrl: RTL and testbench

- Master-side clock-lane TX sequencer in the byte-clock domain.
- Directly drives the LP-TX and HS-TX control inputs of the universal clock-lane PHY model: DTXLPP, DTXLPN, TXLPEN, TXHSEN, TXHSPD and TXHSGATE.
- Performs the D-PHY clock-lane entry sequence LP-11 → LP-01 → LP-00 → HS-0 → toggling, and the exit sequence toggling → HS-0 trail → LP-11, all with programmable byte-clock-count timers.
- Tells the data-lane controllers when the HS clock is valid.

---
 rtl/mipi_clk_lane_tx_ctrl.sv | 98 +++++++++
 tb/tb_mipi_clk_lane_tx_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mipi_clk_lane_tx_ctrl.sv
// D-PHY clock-lane TX sequencer: walks LP-11 -> LP-01 -> LP-00 -> HS-0 -> toggling and back,
// driving the PHY's LP/HS control pins from a single registered state machine.
module mipi_clk_lane_tx_ctrl #(
  parameter int CNT_W     = 8,
  parameter int T_LPX     = 2,
  parameter int T_PREPARE = 3,
  parameter int T_ZERO    = 8,
  parameter int T_PRE     = 2,
  parameter int T_POST    = 4,
  parameter int T_TRAIL   = 3,
  parameter int T_EXIT    = 3
) (
  input  logic       BYTECLK,
  input  logic       RST,
  input  logic       TXREQUESTHS,
  output logic       DTXLPP,
  output logic       DTXLPN,
  output logic       TXLPEN,
  output logic       TXHSEN,
  output logic       TXHSPD,
  output logic       TXHSGATE,
  output logic       CLK_ACTIVE,
  output logic       STOPSTATE,
  output logic [2:0] STATE
);

  typedef enum logic [3:0] {
    S_STOP, S_HS_RQST, S_PREPARE, S_ZERO, S_PRE,
    S_HS_ACTIVE, S_POST, S_TRAIL, S_EXIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;

  function automatic logic [CNT_W-1:0] load_val(state_t s);
    case (s)
      S_HS_RQST: return CNT_W'(T_LPX - 1);
      S_PREPARE: return CNT_W'(T_PREPARE - 1);
      S_ZERO:    return CNT_W'(T_ZERO - 1);
      S_PRE:     return CNT_W'(T_PRE - 1);
      S_POST:    return CNT_W'(T_POST - 1);
      S_TRAIL:   return CNT_W'(T_TRAIL - 1);
      S_EXIT:    return CNT_W'(T_EXIT - 1);
      default:   return '0;
    endcase
  endfunction

  // {STATE, DTXLPP, DTXLPN, TXLPEN, TXHSEN, TXHSPD, TXHSGATE, CLK_ACTIVE, STOPSTATE}
  function automatic logic [10:0] decode(state_t s);
    case (s)
      S_STOP:      return {3'd0, 8'b1110_1101};
      S_HS_RQST:   return {3'd1, 8'b0110_1100};
      S_PREPARE:   return {3'd2, 8'b0011_0100};
      S_ZERO:      return {3'd3, 8'b0001_0100};
      S_PRE:       return {3'd4, 8'b0001_0000};
      S_HS_ACTIVE: return {3'd5, 8'b0001_0010};
      S_POST:      return {3'd6, 8'b0001_0000};
      S_TRAIL:     return {3'd7, 8'b0001_0100};
      S_EXIT:      return {3'd0, 8'b1110_1100};
      default:     return {3'd0, 8'b1110_1101};
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    timer_nxt = (timer == '0) ? '0 : timer - 1'b1;
    case (state)
      S_STOP:      if (TXREQUESTHS)    state_nxt = S_HS_RQST;
      S_HS_RQST:   if (timer == '0)    state_nxt = S_PREPARE;
      S_PREPARE:   if (timer == '0)    state_nxt = S_ZERO;
      S_ZERO:      if (timer == '0)    state_nxt = S_PRE;
      S_PRE:       if (timer == '0)    state_nxt = S_HS_ACTIVE;
      S_HS_ACTIVE: if (!TXREQUESTHS)   state_nxt = S_POST;
      S_POST:      if (timer == '0)    state_nxt = S_TRAIL;
      S_TRAIL:     if (timer == '0)    state_nxt = S_EXIT;
      S_EXIT:      if (timer == '0)    state_nxt = S_STOP;
      default:                         state_nxt = S_STOP;
    endcase
    // Every transition lands in a fresh phase, so reload on any state change.
    if (state_nxt != state) timer_nxt = load_val(state_nxt);
  end

  // Outputs are decoded from the next state so they move on the same edge as STATE.
  always_ff @(posedge BYTECLK or posedge RST) begin
    if (RST) begin
      state <= S_STOP;
      timer <= '0;
      {STATE, DTXLPP, DTXLPN, TXLPEN, TXHSEN, TXHSPD, TXHSGATE, CLK_ACTIVE, STOPSTATE}
        <= decode(S_STOP);
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      {STATE, DTXLPP, DTXLPN, TXLPEN, TXHSEN, TXHSPD, TXHSGATE, CLK_ACTIVE, STOPSTATE}
        <= decode(state_nxt);
    end
  end

endmodule

// File: tb/tb_mipi_clk_lane_tx_ctrl.sv
// Bench for the clock-lane TX sequencer: phase-table reference model feeding an
// expected-output queue, popped and compared by a negedge monitor.
module tb_mipi_clk_lane_tx_ctrl;

  localparam int T_LPX = 2, T_PREPARE = 3, T_ZERO = 8, T_PRE = 2;
  localparam int T_POST = 4, T_TRAIL = 3, T_EXIT = 3;
  localparam logic [10:0] STOP_V = {3'd0, 8'b1110_1101};

  logic       BYTECLK, RST, TXREQUESTHS;
  logic       DTXLPP, DTXLPN, TXLPEN, TXHSEN, TXHSPD, TXHSGATE, CLK_ACTIVE, STOPSTATE;
  logic [2:0] STATE;
  logic       clk_en;

  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_phase  = 0;
  int          m_cnt    = 0;

  mipi_clk_lane_tx_ctrl dut (
    .BYTECLK(BYTECLK), .RST(RST), .TXREQUESTHS(TXREQUESTHS),
    .DTXLPP(DTXLPP), .DTXLPN(DTXLPN), .TXLPEN(TXLPEN), .TXHSEN(TXHSEN),
    .TXHSPD(TXHSPD), .TXHSGATE(TXHSGATE), .CLK_ACTIVE(CLK_ACTIVE),
    .STOPSTATE(STOPSTATE), .STATE(STATE)
  );

  // clock / reset
  initial BYTECLK = 1'b0;
  always begin
    #5;
    if (clk_en) BYTECLK = ~BYTECLK;
  end

  function automatic logic [10:0] dut_vec();
    return {STATE, DTXLPP, DTXLPN, TXLPEN, TXHSEN, TXHSPD, TXHSGATE, CLK_ACTIVE, STOPSTATE};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: phase order STOP, HS_RQST, PREPARE, ZERO, PRE, HS_ACTIVE, POST, TRAIL, EXIT.
  function automatic logic [10:0] phase_out(int p);
    case (p)
      0: return {3'd0, 8'b1110_1101};
      1: return {3'd1, 8'b0110_1100};
      2: return {3'd2, 8'b0011_0100};
      3: return {3'd3, 8'b0001_0100};
      4: return {3'd4, 8'b0001_0000};
      5: return {3'd5, 8'b0001_0010};
      6: return {3'd6, 8'b0001_0000};
      7: return {3'd7, 8'b0001_0100};
      default: return {3'd0, 8'b1110_1100};
    endcase
  endfunction

  function automatic int phase_len(int p);
    case (p)
      1: return T_LPX;
      2: return T_PREPARE;
      3: return T_ZERO;
      4: return T_PRE;
      6: return T_POST;
      7: return T_TRAIL;
      8: return T_EXIT;
      default: return 0;
    endcase
  endfunction

  initial forever begin
    @(posedge BYTECLK);
    if (RST) begin
      m_phase = 0;
      m_cnt   = 0;
      exp_q.delete();
    end else begin
      if (m_phase == 0) begin
        if (TXREQUESTHS) begin m_phase = 1; m_cnt = 1; end
      end else if (m_phase == 5) begin
        if (!TXREQUESTHS) begin m_phase = 6; m_cnt = 1; end
      end else if (m_cnt >= phase_len(m_phase)) begin
        m_phase = (m_phase == 8) ? 0 : m_phase + 1;
        m_cnt   = 1;
      end else begin
        m_cnt++;
      end
      exp_q.push_back(phase_out(m_phase));
    end
  end

  // monitor / scoreboard
  initial forever begin
    logic [10:0] e;
    @(negedge BYTECLK);
    if (!RST && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", dut_vec(), e);
      check("hsen_vs_hspd", {10'd0, TXHSEN}, {10'd0, ~TXHSPD});
    end
  end

  // driver
  task automatic drive(input logic req, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge BYTECLK);
      TXREQUESTHS = req;
    end
  endtask

  initial begin
    int edge_idx;
    bit found;
    clk_en = 1'b0;
    RST = 1'b0;
    TXREQUESTHS = 1'b0;

    // asynchronous reset with the clock stopped
    #3 RST = 1'b1;
    #1 check("reset_async", dut_vec(), STOP_V);
    clk_en = 1'b1;
    repeat (2) @(negedge BYTECLK);
    RST = 1'b0;

    // entry latency from the accepting edge to CLK_ACTIVE
    drive(1'b1, 1);
    edge_idx = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge BYTECLK);
      #1;
      if (CLK_ACTIVE) begin found = 1'b1; break; end
      edge_idx++;
    end
    check("entry_latency", found ? 11'(edge_idx) : 11'h7ff, 11'(T_LPX + T_PREPARE + T_ZERO + T_PRE));

    // normal exit, then 1-cycle pulse, then drop/re-raise back-to-back
    drive(1'b1, 3);
    drive(1'b0, 16);
    drive(1'b1, 1);
    drive(1'b0, 30);
    drive(1'b1, 20);
    drive(1'b0, 1);
    drive(1'b1, 30);
    drive(1'b0, 20);

    // reset while in ZERO
    drive(1'b1, 1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge BYTECLK);
      if (m_phase == 3) begin found = 1'b1; break; end
    end
    check("reach_zero", {10'd0, found}, 11'd1);
    #2 RST = 1'b1;
    #1 check("reset_midop", dut_vec(), STOP_V);
    repeat (2) @(negedge BYTECLK);
    TXREQUESTHS = 1'b1;
    #2 RST = 1'b0;
    drive(1'b1, 20);
    drive(1'b0, 20);

    // randomized request runs
    for (int i = 0; i < 2000; i++) begin
      @(negedge BYTECLK);
      if ($urandom_range(0, 19) == 0) TXREQUESTHS = ~TXREQUESTHS;
    end
    drive(1'b0, 40);
    @(negedge BYTECLK);
    check("queue_drained", 11'(exp_q.size()), 11'd0);
    check("final_stop", dut_vec(), STOP_V);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
